// File: rtl/vco_adc_pkg.sv
// Shared types, default widths and width helper for the VCO ADC controller.
package vco_adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_ACCUM = 2'd2
    } vco_adc_state_t;

    localparam int unsigned PHASE_WIDTH_DEF = 11;
    localparam int unsigned OSR_WIDTH_DEF   = 10;

    // Accumulator width large enough for (2^pw-1)*(2^ow-1) without overflow.
    function automatic int unsigned sum_width(input int unsigned pw, input int unsigned ow);
        return pw + ow;
    endfunction

    localparam int unsigned SUM_WIDTH_DEF = sum_width(PHASE_WIDTH_DEF, OSR_WIDTH_DEF);

endpackage

// File: rtl/vco_adc_if.sv
// Valid/ready sample bus between the decimator and its consumer.
interface vco_adc_if
    import vco_adc_pkg::*;
#(
    parameter int unsigned SUM_WIDTH = SUM_WIDTH_DEF
);

    logic [SUM_WIDTH-1:0] data_out;
    logic                 valid_out;
    logic                 ready_in;

    modport master (output data_out, output valid_out, input ready_in);
    modport slave  (input data_out, input valid_out, output ready_in);

endinterface

// File: rtl/vco_adc_ctrl_phase_diff.sv
// Previous-phase register plus modulo-2^PHASE_WIDTH first difference.
module vco_phase_diff
    import vco_adc_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = PHASE_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_load,
    input  logic                   i_en,
    input  logic [PHASE_WIDTH-1:0] i_phase,
    output logic [PHASE_WIDTH-1:0] o_diff_c
);

    logic [PHASE_WIDTH-1:0] r_p_prev;

    // Track the last sampled phase while priming or accumulating.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p_prev <= '0;
        end else if (i_load || i_en) begin
            r_p_prev <= i_phase;
        end
    end

    // Unsigned wrap of the subtraction absorbs phase roll-over.
    assign o_diff_c = i_phase - r_p_prev;

endmodule

// File: rtl/vco_adc_ctrl.sv
// VCO ADC sequencer: phase differencing, windowed accumulation, output register.
module vco_adc_ctrl
    import vco_adc_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = PHASE_WIDTH_DEF,
    parameter int unsigned OSR_WIDTH   = OSR_WIDTH_DEF,
    parameter int unsigned SUM_WIDTH   = sum_width(PHASE_WIDTH, OSR_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable_in,
    input  logic [OSR_WIDTH-1:0]   osr_in,
    input  logic [PHASE_WIDTH-1:0] p_in,
    vco_adc_if.master              bus,
    output logic                   overrun_out,
    output logic                   busy_out
);

    vco_adc_state_t         r_state;
    vco_adc_state_t         w_next;
    logic [OSR_WIDTH-1:0]   r_osr_q;
    logic [OSR_WIDTH-1:0]   r_cnt;
    logic [SUM_WIDTH-1:0]   r_acc;
    logic [SUM_WIDTH-1:0]   r_data;
    logic                   r_valid;
    logic                   r_overrun;
    logic                   r_busy;

    logic                   w_start_c;
    logic                   w_prime_c;
    logic                   w_accum_c;
    logic                   w_win_done_c;
    logic                   w_xfer_c;
    logic [PHASE_WIDTH-1:0] w_diff_c;
    logic [SUM_WIDTH-1:0]   w_sum_c;
    logic [OSR_WIDTH-1:0]   w_last_c;

    vco_phase_diff #(
        .PHASE_WIDTH (PHASE_WIDTH)
    ) u_phase_diff (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_prime_c),
        .i_en     (w_accum_c),
        .i_phase  (p_in),
        .o_diff_c (w_diff_c)
    );

    assign w_last_c = r_osr_q - OSR_WIDTH'(1);
    assign w_sum_c  = r_acc + SUM_WIDTH'(w_diff_c);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        w_next       = r_state;
        w_start_c    = 1'b0;
        w_prime_c    = 1'b0;
        w_accum_c    = 1'b0;
        w_win_done_c = 1'b0;
        w_xfer_c     = r_valid && bus.ready_in;
        case (r_state)
            ST_IDLE: begin
                if (enable_in) begin
                    w_next    = ST_PRIME;
                    w_start_c = 1'b1;
                end
            end
            ST_PRIME: begin
                w_prime_c = 1'b1;
                w_next    = enable_in ? ST_ACCUM : ST_IDLE;
            end
            ST_ACCUM: begin
                w_accum_c = 1'b1;
                if (!enable_in) begin
                    w_next = ST_IDLE;
                end else if (r_cnt == w_last_c) begin
                    w_win_done_c = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Window counter, accumulator and latched oversampling ratio.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_osr_q <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else if (w_start_c) begin
            r_osr_q <= (osr_in == '0) ? OSR_WIDTH'(1) : osr_in;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else if (w_win_done_c) begin
            r_cnt   <= '0;
            r_acc   <= '0;
        end else if (w_accum_c && enable_in) begin
            r_cnt   <= r_cnt + OSR_WIDTH'(1);
            r_acc   <= w_sum_c;
        end
    end

    // Output sample register with overrun detection; overrun clears on a new run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_start_c) begin
                r_overrun <= 1'b0;
            end
            if (w_win_done_c) begin
                if (!r_valid || w_xfer_c) begin
                    r_data  <= w_sum_c;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_xfer_c) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Busy tracks the state register one-for-one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_next != ST_IDLE);
        end
    end

    assign bus.data_out  = r_data;
    assign bus.valid_out = r_valid;
    assign overrun_out   = r_overrun;
    assign busy_out      = r_busy;

endmodule

// File: tb/tb_vco_adc_ctrl.sv
// Directed bench for vco_adc_ctrl: latency, wrap, backpressure, abort, reset.
module tb_vco_adc_ctrl;
    import vco_adc_pkg::*;

    localparam int unsigned PW = PHASE_WIDTH_DEF;
    localparam int unsigned OW = OSR_WIDTH_DEF;
    localparam int unsigned SW = SUM_WIDTH_DEF;

    logic          clk;
    logic          rst;
    logic          enable_in;
    logic [OW-1:0] osr_in;
    logic [PW-1:0] p_in;
    logic [PW-1:0] step;
    logic          overrun_out;
    logic          busy_out;

    int n_vec;
    int n_err;

    vco_adc_if #(.SUM_WIDTH(SW)) bus ();

    vco_adc_ctrl #(
        .PHASE_WIDTH (PW),
        .OSR_WIDTH   (OW),
        .SUM_WIDTH   (SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable_in   (enable_in),
        .osr_in      (osr_in),
        .p_in        (p_in),
        .bus         (bus),
        .overrun_out (overrun_out),
        .busy_out    (busy_out)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // One clock: outputs are sampled 1 ns after the edge, then the phase ramps.
    task automatic tick();
        @(posedge clk);
        #1;
        p_in = p_in + step;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        enable_in   = 1'b0;
        osr_in      = '0;
        p_in        = '0;
        step        = '0;
        bus.ready_in = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_data",    32'(bus.data_out),  32'd0);
        chk("rst_valid",   32'(bus.valid_out), 32'd0);
        chk("rst_overrun", 32'(overrun_out),   32'd0);
        chk("rst_busy",    32'(busy_out),      32'd0);
        rst = 1'b0;
        tick();

        // Step 5, osr 4: first sample 6 cycles after enable, then every 4
        p_in = 11'd0; step = 11'd5; osr_in = 10'd4; enable_in = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            chk("t1_valid", 32'(bus.valid_out), 32'((k >= 6) && (((k - 6) % 4) == 0)));
            if (k >= 6) chk("t1_data", 32'(bus.data_out), 32'd20);
            if (k == 1) chk("t1_busy", 32'(busy_out), 32'd1);
        end

        // Phase wrap with osr 1, then osr 0 which must behave the same
        for (int pass = 0; pass < 2; pass++) begin
            enable_in = 1'b0;
            tick(); tick(); tick();
            chk("t2_idle_busy", 32'(busy_out), 32'd0);
            p_in = 11'd2040; step = 11'd3;
            osr_in = (pass == 0) ? 10'd1 : 10'd0;
            enable_in = 1'b1;
            for (int k = 1; k <= 7; k++) begin
                tick();
                chk("t2_valid", 32'(bus.valid_out), 32'(k >= 3));
                if (k >= 3) chk("t2_data", 32'(bus.data_out), 32'd3);
            end
        end

        // Backpressure: step 2, osr 3, consumer stalled
        enable_in = 1'b0;
        tick(); tick(); tick();
        p_in = 11'd100; step = 11'd2; osr_in = 10'd3; bus.ready_in = 1'b0;
        enable_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t3_valid",   32'(bus.valid_out), 32'(k >= 5));
            chk("t3_overrun", 32'(overrun_out),   32'(k >= 8));
            if (k >= 5) chk("t3_data", 32'(bus.data_out), 32'd6);
        end
        bus.ready_in = 1'b1;
        tick();
        chk("t3_xfer_valid", 32'(bus.valid_out), 32'd0);
        tick();
        chk("t3_gap_valid",  32'(bus.valid_out), 32'd0);
        tick();
        chk("t3_next_valid", 32'(bus.valid_out), 32'd1);
        chk("t3_next_data",  32'(bus.data_out),  32'd6);
        chk("t3_sticky",     32'(overrun_out),   32'd1);

        // Window result coinciding with a transfer
        enable_in = 1'b0;
        tick(); tick(); tick();
        chk("t4_sticky_idle", 32'(overrun_out), 32'd1);
        p_in = 11'd0; step = 11'd2; osr_in = 10'd3; bus.ready_in = 1'b0;
        enable_in = 1'b1;
        tick();
        chk("t4_overrun_clr", 32'(overrun_out), 32'd0);
        tick(); tick(); tick(); tick();
        chk("t4_first_valid", 32'(bus.valid_out), 32'd1);
        chk("t4_first_data",  32'(bus.data_out),  32'd6);
        step = 11'd4;
        tick(); tick();
        chk("t4_hold_data", 32'(bus.data_out), 32'd6);
        bus.ready_in = 1'b1;
        tick();
        chk("t4_coinc_valid",   32'(bus.valid_out), 32'd1);
        chk("t4_coinc_data",    32'(bus.data_out),  32'd10);
        chk("t4_coinc_overrun", 32'(overrun_out),   32'd0);
        bus.ready_in = 1'b0;
        tick();
        chk("t4_pend_data", 32'(bus.data_out), 32'd10);

        // Abort with a pending sample held
        enable_in = 1'b0;
        tick();
        chk("t5_abort_busy",  32'(busy_out),      32'd0);
        chk("t5_abort_valid", 32'(bus.valid_out), 32'd1);
        p_in = 11'd0; step = 11'd1; osr_in = 10'd8; enable_in = 1'b1;
        tick(); tick(); tick(); tick();
        enable_in = 1'b0;
        tick();
        chk("t5_mid_busy",  32'(busy_out),      32'd0);
        chk("t5_mid_valid", 32'(bus.valid_out), 32'd1);
        chk("t5_mid_data",  32'(bus.data_out),  32'd10);
        bus.ready_in = 1'b1;
        tick();
        chk("t5_deliver_valid", 32'(bus.valid_out), 32'd0);
        // Re-enable: osr change after IDLE must be ignored
        osr_in = 10'd8; enable_in = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) osr_in = 10'd2;
            chk("t5_re_valid", 32'(bus.valid_out), 32'(k == 10));
        end
        chk("t5_re_data", 32'(bus.data_out), 32'd8);

        // Reset mid-window with a pending sample
        bus.ready_in = 1'b0;
        tick(); tick();
        chk("t6_pre_valid", 32'(bus.valid_out), 32'd1);
        rst = 1'b1;
        tick();
        chk("t6_rst_data",  32'(bus.data_out),  32'd0);
        chk("t6_rst_valid", 32'(bus.valid_out), 32'd0);
        chk("t6_rst_busy",  32'(busy_out),      32'd0);
        chk("t6_rst_ovr",   32'(overrun_out),   32'd0);
        rst = 1'b0; enable_in = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("t6_quiet_valid", 32'(bus.valid_out), 32'd0);
        end
        chk("t6_quiet_busy", 32'(busy_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vco_adc_ctrl.md
# vco_adc_ctrl

Sequencer and first-stage decimator for the VCO-based ADC. Samples the VCO phase bus every `clk`, forms the modulo-2^PHASE_WIDTH first difference (the frequency estimate), and accumulates it over a programmable oversampling window. Each completed window is presented as one output sample on a valid/ready interface. The block sits between the `vco` phase outputs and the downstream digital filter or register interface.

## Interface
- `PHASE_WIDTH`, 11: width of the VCO phase bus.
- `OSR_WIDTH`, 10: width of the oversampling-ratio input; windows of 1..2^OSR_WIDTH-1 cycles are supported.
- `SUM_WIDTH`, PHASE_WIDTH+OSR_WIDTH: width of the output sample.
- `clk`  in  1  system clock, 50 MHz; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable_in`  in  1  high = convert continuously; low = stop and return to IDLE.
- `osr_in`  in  OSR_WIDTH  window length in cycles; latched on IDLE->PRIME; 0 is treated as 1.
- `p_in`  in  PHASE_WIDTH  VCO phase, already synchronous to `clk`.
- `data_out`  out  SUM_WIDTH  accumulated window sum.
- `valid_out`  out  1  `data_out` holds an unconsumed sample.
- `ready_in`  in  1  consumer accepts the sample when `valid_out && ready_in`.
- `overrun_out`  out  1  sticky flag; a completed window was dropped.
- `busy_out`  out  1  state is not IDLE.

## Operation
- States: IDLE, PRIME, ACCUM.
- IDLE -> PRIME when `enable_in`=1. On this transition: latch `osr_in` into `osr_q` (with 0 mapped to 1), clear `overrun_out`, clear the accumulator and window counter.
- PRIME, one cycle: capture `p_prev <= p_in`; no accumulation. Then go to ACCUM.
  - If `enable_in`=0 during PRIME, return to IDLE.
- ACCUM, each cycle:
  - `diff = (p_in - p_prev) mod 2^PHASE_WIDTH`, unsigned, zero-extended to SUM_WIDTH.
  - `p_prev <= p_in`.
  - `cnt` runs from 0 to osr_q-1.
  - If `cnt < osr_q-1`: `acc <= acc + diff`, `cnt++`.
  - If `cnt == osr_q-1`: the window result is `acc + diff`. Clear `acc` and `cnt`, so the next window starts on the next cycle with no gap.
- Output register, on a window result:
  - If `valid_out`=0, or a transfer (`valid_out && ready_in`) happens this cycle: load `data_out`, set `valid_out`=1.
  - Otherwise, drop the result, keep `data_out` unchanged, and set `overrun_out`=1.
- A transfer with no new result clears `valid_out`.
- `data_out` is stable while `valid_out && !ready_in`.
- ACCUM with `enable_in`=0: go to IDLE next cycle. The partial window is discarded. A pending `valid_out`/`data_out` is kept until it is transferred.
- Arithmetic: the accumulator is SUM_WIDTH wide and cannot overflow, since (2^PW-1)·(2^OW-1) < 2^SUM_WIDTH. Phase wrap-around is handled purely by the modulo subtraction.

## Timing
- Reset values: state IDLE; `data_out`=0, `valid_out`=0, `overrun_out`=0, `busy_out`=0; `acc`, `cnt`, `p_prev`, `osr_q` = 0.
- Reset has priority over every other event, including mid-window and with a pending output. The pending sample is lost.
- Latency, with `enable_in` sampled high in IDLE at cycle T0:
  - PRIME at T1, capturing p_in(T1).
  - Diffs accumulated at T2..T(1+osr_q).
  - `valid_out` rises at T(2+osr_q).
  - Subsequent samples follow every osr_q cycles.
- `busy_out` is registered and follows the state.
- Changing `osr_in` outside IDLE has no effect.
- `ready_in` may be held high permanently. Throughput is then one sample per window, including osr_q=1 (one sample every cycle).

## Structure
- Package `vco_adc_pkg` holds:
  - state enum `vco_adc_state_t` (IDLE, PRIME, ACCUM);
  - default width localparams;
  - a function computing SUM_WIDTH.
- One sub-module, `vco_phase_diff`: the registered `p_prev` plus the modulo subtractor, parameterised by PHASE_WIDTH, with a `load` (prime) and `en` input.
- FSM, counter, accumulator and output register stay in the top module.

## Test plan
- p_in increments by 5 per cycle, osr_in=4, `ready_in`=1 -> every `data_out`=20; first `valid_out` exactly 6 cycles after the enable cycle; valid pulses spaced 4 cycles apart.
- Phase wrap: p_in = 2046, 2049 mod 2048 = 1, 4, … (step 3), osr_in=1 -> each sample = 3 with no glitch at the wrap; osr_in=0 gives identical behaviour.
- Backpressure: step 2, osr_in=3, `ready_in`=0 for 8 cycles.
  - Expected: first sample 6 held stable; second window dropped; `overrun_out`=1.
  - After `ready_in` rises: transfer, then the next sample is 6; `overrun_out` stays 1 until the next enable from IDLE.
- Result coinciding with a transfer: `ready_in` pulsed in the same cycle a window completes -> new value loaded, `valid_out` stays 1, `overrun_out` stays 0.
- Abort: `enable_in` dropped mid-window (cnt=2 of osr 8) with a pending valid sample.
  - Expected: IDLE next cycle, `busy_out`=0, partial sum discarded, pending sample still delivered on `ready_in`.
  - Re-enable: latency is again osr+2.
- `rst` asserted mid-window with `valid_out`=1 -> next cycle all outputs 0 and state IDLE; no further valid until re-enabled.
